sound_scheduler: RTL and testbench

//  Arbitrates game sound events (bad collision, good collision, snake move) onto the single

---
 rtl/sound_scheduler_if.sv | 21 ++
 rtl/sound_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sound_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sound_scheduler_if.sv
// Game-side request lines and speaker-side status of the sound scheduler.
interface sound_scheduler_if;
    logic       enable;
    logic       goodColl;
    logic       badColl;
    logic [3:0] direction;
    logic       speaker;
    logic       playSound;
    logic [1:0] active;
    logic [2:0] pending;

    modport master (
        output enable, goodColl, badColl, direction,
        input  speaker, playSound, active, pending
    );

    modport slave (
        input  enable, goodColl, badColl, direction,
        output speaker, playSound, active, pending
    );
endinterface

// File: rtl/sound_scheduler.sv
// Priority arbiter for game sound events driving one square-wave speaker:
// one-deep pending per class, fixed tone length per class, silent gap between tones.
module sound_scheduler #(
    parameter logic [23:0] MOVE_HALF = 24'd25000,
    parameter logic [23:0] GOOD_HALF = 24'd18000,
    parameter logic [23:0] BAD_HALF  = 24'd50000,
    parameter logic [23:0] MOVE_LEN  = 24'd500000,
    parameter logic [23:0] GOOD_LEN  = 24'd2000000,
    parameter logic [23:0] BAD_LEN   = 24'd4000000,
    parameter logic [23:0] GAP_LEN   = 24'd100000
) (
    input logic               clk,
    input logic               rst,
    sound_scheduler_if.slave  bus
);
    localparam int unsigned CW = 24;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t          state, state_n;
    logic [2:0]      req_q, raw, req;
    logic [2:0]      pend, pend_n;
    logic [1:0]      act, act_n, grant, hi;
    logic            spk, spk_n;
    logic [CW-1:0]   half_cnt, half_n, dur_cnt, dur_n, gap_cnt, gap_n;

    function automatic logic [1:0] top_class(input logic [2:0] p);
        if (p[2])      return 2'd3;
        else if (p[1]) return 2'd2;
        else if (p[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [CW-1:0] half_of(input logic [1:0] c);
        case (c)
            2'd1:    return MOVE_HALF;
            2'd2:    return GOOD_HALF;
            2'd3:    return BAD_HALF;
            default: return CW'(1);
        endcase
    endfunction

    function automatic logic [CW-1:0] len_of(input logic [1:0] c);
        case (c)
            2'd1:    return MOVE_LEN;
            2'd2:    return GOOD_LEN;
            2'd3:    return BAD_LEN;
            default: return CW'(1);
        endcase
    endfunction

    function automatic logic [2:0] class_mask(input logic [1:0] c);
        case (c)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Rising-edge detection on the raw request levels {bad, good, move}.
    assign raw = {bus.badColl, bus.goodColl, |bus.direction};
    assign req = raw & ~req_q;
    assign hi  = top_class(pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= 3'b000;
            pend     <= 3'b000;
            act      <= 2'd0;
            spk      <= 1'b0;
            half_cnt <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            req_q    <= raw;
            pend     <= pend_n;
            act      <= act_n;
            spk      <= spk_n;
            half_cnt <= half_n;
            dur_cnt  <= dur_n;
            gap_cnt  <= gap_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        act_n   = act;
        spk_n   = spk;
        half_n  = half_cnt;
        dur_n   = dur_cnt;
        gap_n   = gap_cnt;
        grant   = 2'd0;

        if (!bus.enable) begin
            state_n = IDLE;
            pend_n  = 3'b000;
            act_n   = 2'd0;
            spk_n   = 1'b0;
            half_n  = '0;
            dur_n   = '0;
            gap_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi != 2'd0) grant = hi;
                end
                PLAY: begin
                    // A strictly higher pending class preempts; the current tone is dropped.
                    if (hi > act) begin
                        grant = hi;
                    end else begin
                        if (half_cnt == '0) begin
                            spk_n  = ~spk;
                            half_n = half_of(act) - CW'(1);
                        end else begin
                            half_n = half_cnt - CW'(1);
                        end
                        if (dur_cnt == '0) begin
                            spk_n  = 1'b0;
                            act_n  = 2'd0;
                            half_n = '0;
                            if (GAP_LEN == '0) begin
                                state_n = IDLE;
                            end else begin
                                state_n = GAP;
                                gap_n   = GAP_LEN - CW'(1);
                            end
                        end else begin
                            dur_n = dur_cnt - CW'(1);
                        end
                    end
                end
                GAP: begin
                    spk_n = 1'b0;
                    if (gap_cnt == '0) state_n = IDLE;
                    else               gap_n   = gap_cnt - CW'(1);
                end
                default: state_n = IDLE;
            endcase

            if (grant != 2'd0) begin
                state_n = PLAY;
                act_n   = grant;
                spk_n   = 1'b1;
                half_n  = half_of(grant) - CW'(1);
                dur_n   = len_of(grant) - CW'(1);
            end
            pend_n = (pend & ~class_mask(grant)) | req;
        end
    end

    assign bus.speaker   = spk;
    assign bus.playSound = (state == PLAY);
    assign bus.active    = act;
    assign bus.pending   = pend;
endmodule

// File: tb/tb_sound_scheduler.sv
// Randomised and scenario bench for sound_scheduler against a time-based reference model.
module tb_sound_scheduler;
    localparam logic [23:0] P_MOVE_HALF = 24'd2;
    localparam logic [23:0] P_GOOD_HALF = 24'd3;
    localparam logic [23:0] P_BAD_HALF  = 24'd4;
    localparam logic [23:0] P_MOVE_LEN  = 24'd8;
    localparam logic [23:0] P_GOOD_LEN  = 24'd12;
    localparam logic [23:0] P_BAD_LEN   = 24'd16;
    localparam logic [23:0] P_GAP_LEN   = 24'd4;

    typedef struct packed {
        logic       spk;
        logic       play;
        logic [1:0] act;
        logic [2:0] pend;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sound_scheduler_if bus();

    sound_scheduler #(
        .MOVE_HALF(P_MOVE_HALF), .GOOD_HALF(P_GOOD_HALF), .BAD_HALF(P_BAD_HALF),
        .MOVE_LEN(P_MOVE_LEN),   .GOOD_LEN(P_GOOD_LEN),   .BAD_LEN(P_BAD_LEN),
        .GAP_LEN(P_GAP_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    obs_t exp_q[$];
    int   tone_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int half_of(input int c);
        case (c)
            1: return int'(P_MOVE_HALF);
            2: return int'(P_GOOD_HALF);
            3: return int'(P_BAD_HALF);
            default: return 1;
        endcase
    endfunction

    function automatic int len_of(input int c);
        case (c)
            1: return int'(P_MOVE_LEN);
            2: return int'(P_GOOD_LEN);
            3: return int'(P_BAD_LEN);
            default: return 1;
        endcase
    endfunction

    // Reference: tones described by start time and class; speaker phase from elapsed time.
    initial begin : model
        int       mode, cls, start_s, gap_s, s, hi, grant;
        bit [2:0] pend, prev, raw, req;
        obs_t     e;
        mode = 0; cls = 0; start_s = 0; gap_s = 0; s = 0;
        pend = 3'b000; prev = 3'b000;
        forever begin
            @(negedge clk);
            s++;
            raw = {bus.badColl, bus.goodColl, |bus.direction};
            if (rst) begin
                mode = 0; cls = 0; pend = 3'b000; prev = 3'b000;
            end else begin
                req  = raw & ~prev;
                prev = raw;
                if (!bus.enable) begin
                    mode = 0; cls = 0; pend = 3'b000;
                end else begin
                    hi    = pend[2] ? 3 : pend[1] ? 2 : pend[0] ? 1 : 0;
                    grant = 0;
                    if (mode == 0) begin
                        if (hi != 0) grant = hi;
                    end else if (mode == 1) begin
                        if (hi > cls) grant = hi;
                        else if (s - start_s == len_of(cls)) begin
                            mode  = (P_GAP_LEN == 0) ? 0 : 2;
                            gap_s = s;
                            cls   = 0;
                        end
                    end else if (s - gap_s == int'(P_GAP_LEN)) begin
                        mode = 0;
                    end
                    if (grant != 0) begin
                        mode    = 1;
                        cls     = grant;
                        start_s = s;
                        pend    = pend & ~(3'b001 << (grant - 1));
                        tone_q.push_back(grant);
                    end
                    pend = pend | req;
                end
            end
            e.play = (mode == 1);
            e.act  = e.play ? 2'(cls) : 2'd0;
            e.spk  = e.play && (((s - start_s) / half_of(cls)) % 2 == 0);
            e.pend = pend;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every cycle's outputs and the class order of tone starts.
    initial begin : monitor
        obs_t       got, want;
        logic       pplay;
        logic [1:0] pact;
        int         c;
        pplay = 1'b0; pact = 2'd0;
        forever begin
            @(negedge clk);
            #3;
            got = {bus.speaker, bus.playSound, bus.active, bus.pending};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t got spk=%b play=%b act=%0d pend=%b required an expected entry",
                         $time, got.spk, got.play, got.act, got.pend);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL cycle_outputs t=%0t got spk=%b play=%b act=%0d pend=%b required spk=%b play=%b act=%0d pend=%b",
                             $time, got.spk, got.play, got.act, got.pend,
                             want.spk, want.play, want.act, want.pend);
                end
            end
            if (got.play === 1'b1 && (!pplay || got.act != pact)) begin
                checks++;
                if (tone_q.size() == 0) begin
                    failures++;
                    $display("FAIL tone_start t=%0t got class=%0d required no tone", $time, got.act);
                end else begin
                    c = tone_q.pop_front();
                    if (int'(got.act) != c) begin
                        failures++;
                        $display("FAIL tone_start t=%0t got class=%0d required class=%0d", $time, got.act, c);
                    end
                end
            end
            pplay = (got.play === 1'b1);
            pact  = got.act;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin : stimulus
        rst = 1'b1;
        bus.enable = 1'b1; bus.goodColl = 1'b0; bus.badColl = 1'b0; bus.direction = 4'b0000;
        tick(3);
        rst = 1'b0;

        // Held move level: exactly one tone.
        bus.direction = 4'b0001; tick(40); bus.direction = 4'b0000; tick(4);

        // Simultaneous good and bad: bad first, good after the gap.
        bus.goodColl = 1'b1; bus.badColl = 1'b1; tick(1);
        bus.goodColl = 1'b0; bus.badColl = 1'b0; tick(45);

        // Bad preempts a playing move tone.
        bus.direction = 4'b0100; tick(1); bus.direction = 4'b0000; tick(4);
        bus.badColl = 1'b1; tick(1); bus.badColl = 1'b0; tick(30);

        // Good during bad only queues.
        bus.badColl = 1'b1; tick(1); bus.badColl = 1'b0; tick(5);
        bus.goodColl = 1'b1; tick(1); bus.goodColl = 1'b0; tick(45);

        // Disable mid-tone with a pending move; re-enable with bad held high.
        bus.badColl = 1'b1; tick(1); bus.badColl = 1'b0; tick(4);
        bus.direction = 4'b0001; tick(1); bus.direction = 4'b0000; tick(2);
        bus.enable = 1'b0; bus.badColl = 1'b1; tick(3);
        bus.enable = 1'b1; tick(20); bus.badColl = 1'b0; tick(4);

        // Reset mid-tone with bad held across release.
        bus.direction = 4'b0010; tick(1); bus.direction = 4'b0000; tick(4);
        rst = 1'b1; bus.badColl = 1'b1; tick(2);
        rst = 1'b0; tick(30); bus.badColl = 1'b0; tick(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (bus.enable) begin
                if ($urandom_range(0, 149) == 0) bus.enable = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.enable = 1'b1;
            end
            if ($urandom_range(0, 5) == 0)  bus.goodColl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)  bus.badColl  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                bus.direction = ($urandom_range(0, 1) != 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            tick(1);
        end

        rst = 1'b0; bus.enable = 1'b1;
        bus.goodColl = 1'b0; bus.badColl = 1'b0; bus.direction = 4'b0000;
        tick(60);

        checks++;
        if (tone_q.size() != 0) begin
            failures++;
            $display("FAIL tones_outstanding got %0d unplayed tones required 0", tone_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
